// File: rtl/id_stage.sv
// Instruction decode: field split, 32x32 register file, EX/MEM/WB operand forwarding.
// Latency: one edge from accept to the registered EX outputs.
// Backpressure: ir_ready drops for one cycle on a load-use hazard; a bubble is issued instead.
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ir,
  input  logic        ir_valid,
  output logic        ir_ready,
  input  logic [31:0] alu_rslt,
  input  logic [31:0] mem_fwd_data,
  input  logic        wb_wen,
  input  logic [4:0]  wb_dst,
  input  logic [31:0] wb_data,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [4:0]  shamt,
  output logic [15:0] imm,
  output logic [31:0] rrs,
  output logic [31:0] rrt,
  output logic        out_valid,
  output logic [4:0]  dst,
  output logic        wen,
  output logic        is_load,
  output logic        is_store,
  output logic        ill
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  logic [5:0]  op_d;
  logic [5:0]  fn_d;
  logic [4:0]  rs_a;
  logic [4:0]  rt_a;
  logic [4:0]  rd_a;

  logic        legal;
  logic        reads_rs;
  logic        reads_rt;
  logic        dec_wen;
  logic [4:0]  dec_dst;
  logic        dec_load;
  logic        dec_store;

  logic        stall;
  logic        take;
  logic [31:0] rs_val;
  logic [31:0] rt_val;

  logic [31:0] regs [32];

  // Producer of the value two stages back, kept for MEM forwarding.
  logic [4:0]  mem_dst;
  logic        mem_wen;
  logic        mem_valid;

  assign op_d = ir[31:26];
  assign fn_d = ir[5:0];
  assign rs_a = ir[25:21];
  assign rt_a = ir[20:16];
  assign rd_a = ir[15:11];

  // Decode: legality, which sources are really read, destination and memory kind.
  always_comb begin
    legal     = 1'b0;
    reads_rs  = 1'b0;
    reads_rt  = 1'b0;
    dec_wen   = 1'b0;
    dec_dst   = rt_a;
    dec_load  = 1'b0;
    dec_store = 1'b0;
    case (op_d)
      OP_RTYPE: begin
        case (fn_d)
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
          FN_XOR, FN_NOR, FN_SLT, FN_SLTU: begin
            legal    = 1'b1;
            reads_rs = 1'b1;
            reads_rt = 1'b1;
            dec_wen  = 1'b1;
            dec_dst  = rd_a;
          end
          FN_SLL, FN_SRL: begin
            legal    = 1'b1;
            reads_rt = 1'b1;
            dec_wen  = 1'b1;
            dec_dst  = rd_a;
          end
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        legal    = 1'b1;
        reads_rs = 1'b1;
        dec_wen  = 1'b1;
      end
      OP_LW: begin
        legal    = 1'b1;
        reads_rs = 1'b1;
        dec_wen  = 1'b1;
        dec_load = 1'b1;
      end
      OP_SW: begin
        legal     = 1'b1;
        reads_rs  = 1'b1;
        reads_rt  = 1'b1;
        dec_store = 1'b1;
      end
      default: ;
    endcase
    // Writes to $0 are dropped so nothing downstream forwards them.
    if (dec_dst == 5'd0) dec_wen = 1'b0;
  end

  // Load-use hazard: the load in EX has no data until MEM, so hold fetch one cycle.
  always_comb begin
    stall = ir_valid && out_valid && is_load && (dst != 5'd0) &&
            ((reads_rs && (rs_a == dst)) || (reads_rt && (rt_a == dst)));
  end

  assign ir_ready = !stall;
  assign take     = ir_valid && ir_ready;

  // Operand select: youngest producer first (EX, then MEM, then WB bypass, then regfile).
  always_comb begin
    if (rs_a == 5'd0)                                rs_val = 32'd0;
    else if (out_valid && wen && (dst == rs_a))      rs_val = alu_rslt;
    else if (mem_valid && mem_wen && (mem_dst == rs_a)) rs_val = mem_fwd_data;
    else if (wb_wen && (wb_dst == rs_a))             rs_val = wb_data;
    else                                             rs_val = regs[rs_a];

    if (rt_a == 5'd0)                                rt_val = 32'd0;
    else if (out_valid && wen && (dst == rt_a))      rt_val = alu_rslt;
    else if (mem_valid && mem_wen && (mem_dst == rt_a)) rt_val = mem_fwd_data;
    else if (wb_wen && (wb_dst == rt_a))             rt_val = wb_data;
    else                                             rt_val = regs[rt_a];
  end

  // Register file: cleared on reset, written from WB; $0 is never stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (wb_wen && (wb_dst != 5'd0)) begin
      regs[wb_dst] <= wb_data;
    end
  end

  // EX output register and MEM tracking; stalls and illegal ops issue as bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      opcode    <= '0;
      funct     <= '0;
      shamt     <= '0;
      imm       <= '0;
      rrs       <= '0;
      rrt       <= '0;
      out_valid <= 1'b0;
      dst       <= '0;
      wen       <= 1'b0;
      is_load   <= 1'b0;
      is_store  <= 1'b0;
      ill       <= 1'b0;
      mem_dst   <= '0;
      mem_wen   <= 1'b0;
      mem_valid <= 1'b0;
    end else begin
      opcode    <= ir[31:26];
      funct     <= ir[5:0];
      shamt     <= ir[10:6];
      imm       <= ir[15:0];
      rrs       <= rs_val;
      rrt       <= rt_val;
      out_valid <= take && legal;
      dst       <= dec_dst;
      wen       <= take && legal && dec_wen;
      is_load   <= take && legal && dec_load;
      is_store  <= take && legal && dec_store;
      ill       <= take && !legal;
      mem_dst   <= dst;
      mem_wen   <= wen;
      mem_valid <= out_valid;
    end
  end

endmodule
